conv_window_ctrl: RTL and testbench

Sequencer for the convolution line-buffer chain. It accepts a raster-order pixel stream, drives the push (`input_vld`) and pop (`read_flag`) strobes of the K-1 cascaded `queue_reg` line buffers, and flags when a complete KxK window is present. After the last pixel of a frame it drains the line buffers so their read pointers return to zero. It sits between the image/feature-map source and the conv PE array, one instance per conv layer.

---
 rtl/conv_window_ctrl.sv | 162 ++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
// Sequencer for the K-1 cascaded line buffers that feed one conv layer.
// It takes a raster-order pixel stream, drives the line-buffer push and pop
// strobes, flags each complete KxK window, and drains the buffers after the
// last pixel so their read pointers come back to zero.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous active-low reset
//   ce          clock enable; 0 holds all state and zeroes the strobes/pulses
//   start       frame start request, honoured only in IDLE
//   pix_vld     upstream pixel valid
//   pix_rdy     ready for a pixel (FILL or RUN), combinational
//   lb_push     per line buffer push strobe (input_vld), combinational
//   lb_pop      per line buffer pop strobe (read_flag), combinational
//   win_vld     a full KxK window is available
//   win_row     row of the window's bottom-right pixel
//   win_col     column of the window's bottom-right pixel
//   frame_done  one-cycle pulse at the end of a frame
//   busy        1 in any state other than IDLE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start, pixels ignored
// FILL  | first K-1 rows: priming the line buffers, no windows yet
// RUN   | remaining rows: every accepted pixel may complete a window
// DRAIN | IMG_W pops to every buffer so the read pointers return to 0
// DONE  | one cycle, schedules frame_done then returns to IDLE
module conv_window_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K = 3,
    localparam int CW = $clog2(IMG_W),
    localparam int RW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          start,
    input  logic          pix_vld,
    output logic          pix_rdy,
    output logic [K-2:0]  lb_push,
    output logic [K-2:0]  lb_pop,
    output logic          win_vld,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          frame_done,
    output logic          busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K - 2);
    localparam logic [RW-1:0] ROW_WIN       = RW'(K - 1);
    localparam logic [CW-1:0] COL_WIN       = CW'(K - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] drain_cnt;
    logic          win_vld_q;
    logic          frame_done_q;
    logic          acc;
    logic          col_last;
    logic          win_hit;

    always_comb begin
        pix_rdy  = (state == S_FILL) || (state == S_RUN);
        acc      = ce && pix_vld && pix_rdy;
        col_last = (col == COL_LAST);
        win_hit  = acc && (row >= ROW_WIN) && (col >= COL_WIN);
    end

    // Buffer i holds row (r-i-1) while row r streams in, so it starts
    // receiving at row i and starts emitting one row later.
    always_comb begin
        lb_push = '0;
        lb_pop  = '0;
        if ((state == S_DRAIN) && ce) begin
            lb_pop = '1;
        end else begin
            for (int i = 0; i < K - 1; i++) begin
                lb_push[i] = acc && (int'(row) >= i);
                lb_pop[i]  = acc && (int'(row) > i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (ce && start) state_nxt = S_FILL;
            S_FILL:  if (acc && col_last && (row == ROW_FILL_LAST)) state_nxt = S_RUN;
            S_RUN:   if (acc && col_last && (row == ROW_LAST)) state_nxt = S_DRAIN;
            S_DRAIN: if (ce && (drain_cnt == '0)) state_nxt = S_DONE;
            S_DONE:  if (ce) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            col          <= '0;
            row          <= '0;
            drain_cnt    <= '0;
            win_vld_q    <= 1'b0;
            win_row      <= '0;
            win_col      <= '0;
            frame_done_q <= 1'b0;
        end else if (ce) begin
            state        <= state_nxt;
            busy         <= (state_nxt != S_IDLE);
            win_vld_q    <= win_hit;
            frame_done_q <= (state == S_DONE);
            if (win_hit) begin
                win_row <= row;
                win_col <= col;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        col <= '0;
                        row <= '0;
                    end
                end
                S_FILL, S_RUN: begin
                    if (acc) begin
                        if ((state == S_RUN) && col_last && (row == ROW_LAST)) begin
                            col       <= '0;
                            row       <= '0;
                            drain_cnt <= COL_LAST;
                        end else if (col_last) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The pulses are held across ce=0 bubbles and shown on the next enabled
    // cycle, so a bubble never swallows a window or the end-of-frame pulse.
    assign win_vld    = win_vld_q && ce;
    assign frame_done = frame_done_q && ce;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl at IMG_W=4, IMG_H=4, K=3.
// A frame-level reference model (pixel index, drain countdown, pending
// window/pulse) predicts every strobe and output each cycle, and a
// line-buffer occupancy model watches for underflow/overflow.
module tb_conv_window_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int K = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ce;
    logic         start;
    logic         pix_vld;
    logic         pix_rdy;
    logic [K-2:0] lb_push;
    logic [K-2:0] lb_pop;
    logic         win_vld;
    logic [1:0]   win_row;
    logic [1:0]   win_col;
    logic         frame_done;
    logic         busy;

    conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(K)) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .pix_vld(pix_vld),
        .pix_rdy(pix_rdy), .lb_push(lb_push), .lb_pop(lb_pop),
        .win_vld(win_vld), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int m_phase;      // 0 idle, 1 taking pixels, 2 draining, 3 end of frame
    int m_n;          // pixels accepted this frame
    int m_drain;
    int m_win_pend, m_wr, m_wc;
    int m_fd_pend;
    int occ[K-1];
    int raddr[K-1];

    int got_r[$];
    int got_c[$];
    int fd_seen, drain_pops, bz;
    int exp_r[4] = '{2, 2, 3, 3};
    int exp_c[4] = '{2, 3, 2, 3};

    typedef struct {
        logic       ce, st, pv;
        logic       busy, rdy;
        logic [1:0] push, pop;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_drain = 0;
        m_win_pend = 0; m_wr = 0; m_wc = 0; m_fd_pend = 0;
        for (int i = 0; i < K - 1; i++) begin
            occ[i] = 0;
            raddr[i] = 0;
        end
    endtask

    task automatic frame_begin();
        got_r.delete();
        got_c.delete();
        fd_seen = 0;
        drain_pops = 0;
    endtask

    task automatic cycle(input logic i_ce, input logic i_st, input logic i_pv);
        bit acc;
        int r, c;
        logic [K-2:0] ep, eo;
        logic er;
        logic bad;
        ce = i_ce; start = i_st; pix_vld = i_pv;
        #1;
        if (!rst) begin
            model_reset();
        end else begin
            er  = (m_phase == 1);
            acc = i_ce && i_pv && er;
            r = m_n / W;
            c = m_n % W;
            ep = '0;
            eo = '0;
            if (acc)
                for (int i = 0; i < K - 1; i++) begin
                    ep[i] = (r >= i);
                    eo[i] = (r >= i + 1);
                end
            if (m_phase == 2 && i_ce) eo = '1;
            chk("pix_rdy", pix_rdy, er);
            chk("lb_push", lb_push, ep);
            chk("lb_pop", lb_pop, eo);
            chk("busy", busy, m_phase != 0);
            chk("win_vld", win_vld, i_ce && m_win_pend != 0);
            if (i_ce && m_win_pend != 0) begin
                chk("win_row", win_row, m_wr);
                chk("win_col", win_col, m_wc);
            end
            if (win_vld) begin
                got_r.push_back(int'(win_row));
                got_c.push_back(int'(win_col));
            end
            chk("frame_done", frame_done, i_ce && m_fd_pend != 0);
            if (frame_done) fd_seen++;
            if (!busy) bz++;
            if (lb_pop == '1 && lb_push == '0) drain_pops++;
            bad = 1'b0;
            for (int i = 0; i < K - 1; i++) begin
                if (lb_pop[i] && occ[i] == 0) bad = 1'b1;
                if (lb_push[i] && !lb_pop[i] && occ[i] == W) bad = 1'b1;
                occ[i] = occ[i] + int'(lb_push[i]) - int'(lb_pop[i]);
                if (lb_pop[i]) raddr[i] = (raddr[i] + 1) % W;
            end
            chk("lb_under_overflow", bad, 1'b0);
            if (i_ce) begin
                m_win_pend = 0;
                m_fd_pend = 0;
                if (acc && r >= K - 1 && c >= K - 1) begin
                    m_win_pend = 1; m_wr = r; m_wc = c;
                end
                case (m_phase)
                    0: if (i_st) begin m_phase = 1; m_n = 0; end
                    1: if (acc) begin
                        m_n++;
                        if (m_n == W * H) begin m_phase = 2; m_drain = W; end
                    end
                    2: begin m_drain--; if (m_drain == 0) m_phase = 3; end
                    default: begin m_fd_pend = 1; m_phase = 0; end
                endcase
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame_checks(input string tag);
        chk({tag, "_win_count"}, got_r.size(), 4);
        for (int k = 0; k < 4 && k < got_r.size(); k++)
            chk({tag, "_win_rc"}, got_r[k] * 16 + got_c[k], exp_r[k] * 16 + exp_c[k]);
        chk({tag, "_frame_done_count"}, fd_seen, 1);
        chk({tag, "_drain_pops"}, drain_pops, W);
        for (int i = 0; i < K - 1; i++) begin
            chk({tag, "_lb_occ_end"}, occ[i], 0);
            chk({tag, "_lb_raddr_end"}, raddr[i], 0);
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pix_rdy"}, pix_rdy, 0);
        chk({tag, "_lb_push"}, lb_push, 0);
        chk({tag, "_lb_pop"}, lb_pop, 0);
        chk({tag, "_win_vld"}, win_vld, 0);
        chk({tag, "_win_row"}, win_row, 0);
        chk({tag, "_win_col"}, win_col, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic run_frame(input int gap, input bit hold_start, input bit rand_start,
                             input string tag, output int len);
        bit begun;
        logic c, p, s;
        frame_begin();
        len = 0;
        begun = (m_phase != 0);
        for (int g = 0; g < 600; g++) begin
            c = ($urandom_range(99) >= gap);
            p = ($urandom_range(99) >= gap);
            if (!begun) s = 1'b1;
            else if (hold_start) s = 1'b1;
            else if (rand_start && m_phase != 0) s = ($urandom_range(99) < 30);
            else s = 1'b0;
            cycle(c, s, p);
            len++;
            if (m_phase != 0) begun = 1'b1;
            if (fd_seen != 0) break;
        end
        frame_checks(tag);
    endtask

    initial begin
        int len1, len2, b1;
        rst = 1'b0; ce = 1'b1; start = 1'b1; pix_vld = 1'b1;
        model_reset();
        bz = 0;
        @(negedge clk);

        // reset hold with pix_vld and start high
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
        rst = 1'b1; ce = 1'b0; start = 1'b0; pix_vld = 1'b1;
        #1;
        idle_checks("reset_hold");
        @(negedge clk);

        // table-driven frame opening
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01};
        frame_begin();
        for (int v = 0; v < 12; v++) begin
            ce = tbl[v].ce; start = tbl[v].st; pix_vld = tbl[v].pv;
            #1;
            chk("tbl_busy", busy, tbl[v].busy);
            chk("tbl_pix_rdy", pix_rdy, tbl[v].rdy);
            chk("tbl_lb_push", lb_push, tbl[v].push);
            chk("tbl_lb_pop", lb_pop, tbl[v].pop);
            cycle(tbl[v].ce, tbl[v].st, tbl[v].pv);
        end
        for (int g = 0; g < 100 && fd_seen == 0; g++) cycle(1'b1, 1'b0, 1'b1);
        frame_checks("table_frame");

        // clean frame, exact length
        run_frame(0, 1'b0, 1'b0, "clean", len1);
        chk("clean_frame_len", len1, 1 + W * H + W + 1 + 1);

        // random ce / pix_vld gaps
        for (int k = 0; k < 3; k++) run_frame(30, 1'b0, 1'b0, "gaps", len1);

        // start pulsed during RUN / DRAIN / DONE
        run_frame(0, 1'b0, 1'b1, "start_mid", len1);
        for (int k = 0; k < 2; k++) run_frame(30, 1'b0, 1'b1, "start_mid_gaps", len1);

        // reset after 7 accepted pixels
        frame_begin();
        cycle(1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 50 && m_n < 7; g++) cycle(1'b1, 1'b0, 1'b1);
        chk("pre_reset_accepts", m_n, 7);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b1);
        rst = 1'b1; ce = 1'b1; start = 1'b0; pix_vld = 1'b1;
        #1;
        idle_checks("mid_reset");
        @(negedge clk);
        run_frame(0, 1'b0, 1'b0, "after_reset", len1);

        // back-to-back frames
        run_frame(0, 1'b1, 1'b0, "b2b_first", len1);
        b1 = bz;
        run_frame(0, 1'b0, 1'b0, "b2b_second", len2);
        chk("b2b_idle_cycles", bz - b1, 1);
        chk("b2b_second_len", len2, len1 - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
